// File: rtl/instr_fetch.sv
// Fetch/issue front end for the 4-bit-opcode CPU: owns the PC, fetches one word at a time, holds it in IR.
// Define RETIRE_CNT_EN to add the retire_count output (count of acknowledged instructions).
module instr_fetch #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [15:0]     imem_rdata,
    output logic [3:0]      opcode,
    output logic [3:0]      rs,
    output logic [3:0]      rt,
    output logic [3:0]      rd,
    output logic [3:0]      imm,
    output logic            instr_valid,
    input  logic            instr_ack,
    input  logic            alu_zero,
    output logic [PC_W-1:0] pc
`ifdef RETIRE_CNT_EN
    ,
    output logic [15:0]     retire_count
`endif
);

    localparam logic [3:0]      OP_BEQ = 4'b0110;
    localparam logic [3:0]      OP_JMP = 4'b0111;
    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_ISSUE
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic            req_q, req_d;
    logic            valid_q, valid_d;
    logic [PC_W-1:0] pc_inc, jmp_target, br_offset, next_pc;
    logic            ack_accept;

    assign ack_accept = (state_q == S_ISSUE) && instr_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  if (imem_valid) state_d = S_ISSUE;
            S_ISSUE: if (instr_ack) state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    // Redirection is decoded straight from IR so control-decoder don't-cares cannot disturb the PC.
    always_comb begin
        pc_inc     = pc_q + PC_ONE;
        jmp_target = PC_W'(ir_q[11:0]);
        br_offset  = PC_W'($signed(ir_q[3:0]));
        next_pc    = pc_inc;
        case (ir_q[15:12])
            OP_JMP:  next_pc = jmp_target;
            OP_BEQ:  if (alu_zero) next_pc = pc_inc + br_offset;
            default: next_pc = pc_inc;
        endcase
    end

    always_comb begin
        req_d   = (state_q == S_FETCH);
        ir_d    = ir_q;
        valid_d = valid_q;
        pc_d    = pc_q;
        if ((state_q == S_WAIT) && imem_valid) begin
            ir_d    = imem_rdata;
            valid_d = 1'b1;
        end
        if (ack_accept) begin
            valid_d = 1'b0;
            pc_d    = next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            req_q   <= req_d;
            valid_q <= valid_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign opcode      = ir_q[15:12];
    assign rs          = ir_q[11:8];
    assign rt          = ir_q[7:4];
    assign rd          = ir_q[3:0];
    assign imm         = ir_q[3:0];
    assign instr_valid = valid_q;

`ifdef RETIRE_CNT_EN
    logic [15:0] retire_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_q <= 16'h0000;
        end else if (ack_accept) begin
            retire_q <= retire_q + 16'h0001;
        end
    end

    assign retire_count = retire_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed and randomized instruction streams against a PC/timing reference model.
// Retire counter checks are compiled in when RETIRE_CNT_EN is defined.
module tb_instr_fetch;

    localparam int PC_W = 8;

    logic            clk;
    logic            rst;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [15:0]     imem_rdata;
    logic [3:0]      opcode, rs, rt, rd, imm;
    logic            instr_valid;
    logic            instr_ack;
    logic            alu_zero;
    logic [PC_W-1:0] pc;
`ifdef RETIRE_CNT_EN
    logic [15:0]     retire_count;
`endif

    instr_fetch #(.PC_W(PC_W), .RESET_PC('0)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .imm         (imm),
        .instr_valid (instr_valid),
        .instr_ack   (instr_ack),
        .alu_zero    (alu_zero),
        .pc          (pc)
`ifdef RETIRE_CNT_EN
        ,
        .retire_count(retire_count)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;
    logic [15:0] mem [256];
    int memLat = 1;
    int memCnt = 0;
    logic [PC_W-1:0] memAddr;
    logic [PC_W-1:0] expPc;
    int expRetire = 0;
    int prevReq = -1;
    int expGap = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycleCnt++;

    // Memory answers a request seen in cycle k with one valid cycle at k+memLat; reset does not cancel it.
    always @(negedge clk) begin
        imem_valid = 1'b0;
        imem_rdata = 16'($urandom);
        if (memCnt > 0) begin
            memCnt--;
            if (memCnt == 0) begin
                imem_valid = 1'b1;
                imem_rdata = mem[memAddr];
            end
        end
        if (imem_req === 1'b1) begin
            memCnt  = memLat;
            memAddr = imem_addr;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic finishRun;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeoutFail(input string tag);
        checks++;
        errors++;
        $display("FAIL %s observed=timeout expected=event", tag);
        finishRun();
    endtask

    function automatic logic [PC_W-1:0] modelNext(input int pcv, input logic [15:0] w, input bit z);
        int op;
        int off;
        int res;
        op  = int'(w[15:12]);
        off = int'(w[3:0]);
        if (off >= 8) off = off - 16;
        if (op == 7) res = int'(w[11:0]);
        else if (op == 6 && z) res = pcv + 1 + off;
        else res = pcv + 1;
        res = ((res % 256) + 256) % 256;
        return PC_W'(res);
    endfunction

    task automatic waitReq;
        int ticks;
        ticks = 0;
        while (imem_req !== 1'b1 && ticks < 40) begin
            instr_ack = 1'($urandom_range(0, 1));
            alu_zero  = 1'($urandom_range(0, 1));
            tick();
            ticks++;
        end
        instr_ack = 1'b0;
        if (ticks >= 40) timeoutFail("reqTimeout");
    endtask

    task automatic applyStimulus(input logic [15:0] word, input bit zero, input int lat, input int ackDelay);
        int  ticks;
        bit  extraReq;
        bit  stable;
        memLat     = lat;
        mem[expPc] = word;
        waitReq();
        checkOutput("reqAddr", 32'(imem_addr), 32'(expPc));
        if (prevReq >= 0) checkOutput("reqGap", 32'(cycleCnt - prevReq), 32'(expGap));
        prevReq  = cycleCnt;
        expGap   = lat + 3 + ackDelay;
        ticks    = 0;
        extraReq = 1'b0;
        do begin
            instr_ack = 1'($urandom_range(0, 1));
            alu_zero  = 1'($urandom_range(0, 1));
            tick();
            ticks++;
            if (instr_valid !== 1'b1 && imem_req === 1'b1) extraReq = 1'b1;
        end while (instr_valid !== 1'b1 && ticks < 40);
        instr_ack = 1'b0;
        if (ticks >= 40) timeoutFail("issueTimeout");
        checkOutput("issueLatency", 32'(ticks), 32'(lat + 1));
        checkOutput("extraReq", 32'(extraReq), 32'd0);
        checkOutput("opcode", 32'(opcode), 32'(word[15:12]));
        checkOutput("rs", 32'(rs), 32'(word[11:8]));
        checkOutput("rt", 32'(rt), 32'(word[7:4]));
        checkOutput("rd", 32'(rd), 32'(word[3:0]));
        checkOutput("imm", 32'(imm), 32'(word[3:0]));
        stable = 1'b1;
        for (int i = 0; i < ackDelay; i++) begin
            alu_zero = 1'($urandom_range(0, 1));
            tick();
            if (instr_valid !== 1'b1 || {opcode, rs, rt, rd} !== word || pc !== expPc || imem_req !== 1'b0)
                stable = 1'b0;
        end
        if (ackDelay > 0) checkOutput("holdStable", 32'(stable), 32'd1);
        instr_ack = 1'b1;
        alu_zero  = zero;
        tick();
        instr_ack = 1'b0;
        alu_zero  = 1'($urandom_range(0, 1));
        expPc     = modelNext(int'(expPc), word, zero);
        expRetire = (expRetire + 1) % 65536;
        checkOutput("validAfterAck", 32'(instr_valid), 32'd0);
        checkOutput("nextPc", 32'(pc), 32'(expPc));
`ifdef RETIRE_CNT_EN
        checkOutput("retireCount", 32'(retire_count), 32'(expRetire));
`endif
    endtask

    // Directed sequence first, then random instructions, then a reset that lands mid-read.
    initial begin
        rst       = 1'b1;
        instr_ack = 1'b0;
        alu_zero  = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        tick();
        tick();
        checkOutput("resetReq", 32'(imem_req), 32'd0);
        checkOutput("resetValid", 32'(instr_valid), 32'd0);
        checkOutput("resetPc", 32'(pc), 32'd0);
        checkOutput("resetIr", 32'({opcode, rs, rt, rd}), 32'd0);
`ifdef RETIRE_CNT_EN
        checkOutput("resetRetire", 32'(retire_count), 32'd0);
`endif
        rst       = 1'b0;
        expPc     = '0;
        expRetire = 0;
        tick();
        checkOutput("firstReq", 32'(imem_req), 32'd1);
        checkOutput("firstAddr", 32'(imem_addr), 32'd0);
        checkOutput("firstValid", 32'(instr_valid), 32'd0);

        applyStimulus(16'h0123, 1'b0, 1, 0);
        applyStimulus(16'h8000, 1'b1, 1, 0);
        applyStimulus(16'h1111, 1'b0, 1, 0);
        applyStimulus(16'h2222, 1'b1, 2, 1);
        applyStimulus(16'h7005, 1'b0, 1, 0);
        applyStimulus(16'h600E, 1'b1, 1, 0);
        applyStimulus(16'h7005, 1'b0, 1, 0);
        applyStimulus(16'h600E, 1'b0, 1, 0);
        applyStimulus(16'h7F2A, 1'b1, 1, 0);
        applyStimulus(16'h70FF, 1'b0, 1, 0);
        applyStimulus(16'hF000, 1'b1, 1, 0);
        applyStimulus(16'h1234, 1'b0, 5, 10);
        applyStimulus(16'h6008, 1'b1, 1, 0);
        applyStimulus(16'h6007, 1'b1, 2, 2);

        repeat (25) begin
            applyStimulus(16'($urandom), 1'($urandom_range(0, 1)),
                          int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
        end

        applyStimulus(16'h7040, 1'b0, 1, 0);
        memLat     = 4;
        mem[expPc] = 16'h3CCC;
        waitReq();
        checkOutput("staleReqAddr", 32'(imem_addr), 32'h40);
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        checkOutput("midResetPc", 32'(pc), 32'd0);
        checkOutput("midResetValid", 32'(instr_valid), 32'd0);
        checkOutput("midResetReq", 32'(imem_req), 32'd0);
`ifdef RETIRE_CNT_EN
        checkOutput("midResetRetire", 32'(retire_count), 32'd0);
`endif
        rst       = 1'b0;
        expPc     = '0;
        expRetire = 0;
        prevReq   = -1;
        tick();
        checkOutput("freshReq", 32'(imem_req), 32'd1);
        checkOutput("freshAddr", 32'(imem_addr), 32'd0);
        checkOutput("staleIgnored", 32'(instr_valid), 32'd0);
        applyStimulus(16'h4567, 1'b0, 4, 0);
        applyStimulus(16'h0A5C, 1'b1, 1, 0);
        applyStimulus(16'h6001, 1'b1, 1, 1);

        finishRun();
    end

endmodule
